// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Scan-phase generator and frame-synchronous data holder for the 4-digit
// display multiplexer.
//
// A prescaler divides clk down so that the 4-bit scan phase `count` advances
// once every DIV_MAX+1 clocks. Bytes loaded from the UART side sit in a
// one-entry pending buffer and are copied to `disp_data` only when the scan
// wraps from phase 15 to phase 0. Every digit of a frame therefore shows
// nibbles taken from the same byte.
//
// Optional feature (compile-time macro SCAN_FREEZE_EN):
//   When defined, adds the input `freeze`. While it is high the prescaler and
//   the scan phase hold and no frame boundary can occur. Loads are still
//   accepted.
//
// Parameters:
//   DIV_WIDTH  width of the prescaler counter
//   DIV_MAX    terminal prescaler value (must be <= 2^DIV_WIDTH-1)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   freeze      (SCAN_FREEZE_EN only) hold scanning while high
//   data_in     byte to display
//   data_load   one-cycle strobe capturing data_in into the pending buffer
//   count       scan phase 0..15 to the multiplexer
//   disp_data   byte currently displayed, stable for a whole frame
//   pending     a loaded byte is waiting for the next frame boundary
//   frame_tick  one-cycle pulse on the first clock of a new frame
//   overrun     sticky: a still-pending byte was overwritten by a new load
module disp_scan_ctrl #(
  parameter int unsigned          DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_MAX   = 16'd49999
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SCAN_FREEZE_EN
  input  logic       freeze,
`endif
  input  logic [7:0] data_in,
  input  logic       data_load,
  output logic [3:0] count,
  output logic [7:0] disp_data,
  output logic       pending,
  output logic       frame_tick,
  output logic       overrun
);

  localparam logic [DIV_WIDTH-1:0] PRE_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] prescaler;
  logic [7:0]           pend_buf;
  logic                 run;
  logic                 step;
  logic                 wrap;

`ifdef SCAN_FREEZE_EN
  assign run = ~freeze;
`else
  assign run = 1'b1;
`endif

  // step: the last prescaler clock of a phase. wrap: the last clock of a frame.
  assign step = run && (prescaler == DIV_MAX);
  assign wrap = step && (count == 4'd15);

  // Scan timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      count      <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (run) begin
        if (step) begin
          prescaler <= '0;
          count     <= count + 4'd1;
        end else begin
          prescaler <= prescaler + PRE_ONE;
        end
      end
    end
  end

  // Pending buffer and displayed byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_buf  <= 8'h00;
      pending   <= 1'b0;
      disp_data <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      // The commit reads the buffer value from before this edge. A load on
      // the same edge therefore queues behind the byte that is committing.
      if (wrap && pending) begin
        disp_data <= pend_buf;
      end
      if (data_load) begin
        pend_buf <= data_in;
        pending  <= 1'b1;
        // On a wrap edge the old byte leaves the buffer, so nothing is lost.
        if (pending && !wrap) begin
          overrun <= 1'b1;
        end
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
